// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Launch/abort/result bundle between EX-stage control and the
//            iterative RV32M multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface muldiv_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [2:0]   funct3;
    logic [N-1:0] rs1;
    logic [N-1:0] rs2;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, funct3, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1, rs2, flush,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a
//            fixed N+1 cycle latency and synchronous flush.
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int N = 32
) (
    input  wire logic     clk_i,
    input  wire logic     rst_ni,
    muldiv_unit_if.slave  bus
);
    localparam int            CW     = $clog2(N) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [N-1:0]  C_MINV = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    b_q, b_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [N-1:0]    quo_q, quo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N-1:0]    result_q, result_d;

    // Operand conditioning at capture
    logic         w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [N-1:0] w_a_mag, w_b_mag;

    assign w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                        (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                        (bus.funct3 == 3'b110);
    assign w_a_neg    = w_a_signed && bus.rs1[N-1];
    assign w_b_neg    = w_b_signed && bus.rs2[N-1];
    assign w_a_mag    = w_a_neg ? (~bus.rs1 + 1'b1) : bus.rs1;
    assign w_b_mag    = w_b_neg ? (~bus.rs2 + 1'b1) : bus.rs2;

    // Iteration datapaths
    logic [N:0]   w_sum;
    logic [N:0]   w_shift;
    logic         w_ge;
    logic [N-1:0] w_diff;

    assign w_sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? b_q : {N{1'b0}})};
    assign w_shift = {rem_q, quo_q[N-1]};
    assign w_ge    = (w_shift >= {1'b0, b_q});
    // When w_ge holds the true difference is below the divisor, so the low N bits are exact.
    assign w_diff  = w_shift[N-1:0] - b_q;

    // Sign fix-up and special-case selection
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quo, w_rem, w_fin;

    assign w_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign w_quo  = (neg_q && !div0_q) ? (~quo_q + 1'b1) : quo_q;
    assign w_rem  = rneg_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        w_fin = w_quo;
        if (!op_q[2]) begin
            w_fin = (op_q[1:0] == 2'b00) ? w_prod[N-1:0] : w_prod[2*N-1:N];
        end else if (ovf_q) begin
            w_fin = op_q[1] ? {N{1'b0}} : C_MINV;
        end else if (div0_q) begin
            w_fin = op_q[1] ? w_rem : {N{1'b1}};
        end else begin
            w_fin = op_q[1] ? w_rem : w_quo;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    op_d    = bus.funct3;
                    neg_d   = w_a_neg ^ w_b_neg;
                    rneg_d  = w_a_neg;
                    div0_d  = (bus.rs2 == {N{1'b0}});
                    ovf_d   = bus.funct3[2] && !bus.funct3[0] &&
                              (bus.rs1 == C_MINV) && (bus.rs2 == {N{1'b1}});
                    b_d     = w_b_mag;
                    acc_d   = {{N{1'b0}}, w_a_mag};
                    rem_d   = {N{1'b0}};
                    quo_d   = w_a_mag;
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    quo_d = {quo_q[N-2:0], w_ge};
                    rem_d = w_ge ? w_diff : w_shift[N-1:0];
                end else begin
                    acc_d = {w_sum, acc_q[N-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                end
            end
            S_FIN: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                result_d = w_fin;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort dominates everything, including a same-cycle launch.
        if (bus.flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 3'b000;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Scoreboard bench for muldiv_unit: directed vectors, latency,
//            flush, ignored start, back-to-back and async reset.
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;
    localparam int N = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [N-1:0] res;
        int           due;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    muldiv_unit_if #(.N(N)) bus ();

    muldiv_unit #(.N(N)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with result %h, expected no done", bus.result);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_result"}, bus.result, e.res);
                check({e.name, "_latency"}, N'(cyc), N'(e.due));
            end
        end
    end

    // Called on a falling edge; the following rising edge is E0.
    task automatic issue(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] r, input bit push, input string nm);
        bus.funct3 = f;
        bus.rs1    = a;
        bus.rs2    = b;
        bus.start  = 1'b1;
        if (push) exp_q.push_back('{r, cyc + N + 2, nm});
        @(negedge clk);
        bus.start = 1'b0;
        bus.rs1   = $urandom;
        bus.rs2   = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 4 * N) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.rs1    = '0;
        bus.rs2    = '0;

        repeat (2) @(negedge clk);
        check("reset_busy",   {31'b0, bus.busy},  32'd0);
        check("reset_done",   {31'b0, bus.done},  32'd0);
        check("reset_result", bus.result,         32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, "mul_7xm3");
        drain();

        // Asynchronous reset in the middle of an operation
        issue(3'b000, 32'd6, 32'd7, 32'd0, 1'b0, "mul_aborted");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy",   {31'b0, bus.busy}, 32'd0);
        check("midreset_done",   {31'b0, bus.done}, 32'd0);
        check("midreset_result", bus.result,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, "mulh_min");
        drain();
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, "mulhu_max");
        drain();
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mulhsu_m1");
        drain();
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, "div_m7_2");
        drain();
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, "rem_m7_2");
        drain();
        issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b1, "divu_100_7");
        drain();
        issue(3'b111, 32'd100, 32'd7, 32'd2, 1'b1, "remu_100_7");
        drain();
        issue(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_by0");
        drain();
        issue(3'b111, 32'd5, 32'd0, 32'd5, 1'b1, "remu_by0");
        drain();
        issue(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1, "rem_neg_by0");
        drain();
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
        drain();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "rem_ovf");
        drain();

        // Flush mid-calculation: no done, result retained
        issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b1, "divu_pre_flush");
        drain();
        issue(3'b000, 32'd123, 32'd456, 32'd0, 1'b0, "mul_flushed");
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        repeat (2 * N) @(negedge clk);
        check("flush_result_kept", bus.result, 32'd14);

        // Start while busy is ignored
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, "mulhu_busy_start");
        repeat (5) @(negedge clk);
        bus.funct3 = 3'b000;
        bus.rs1    = 32'd3;
        bus.rs2    = 32'd5;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (N) @(negedge clk);

        // Flush and start together in idle
        bus.funct3 = 3'b000;
        bus.rs1    = 32'd9;
        bus.rs2    = 32'd9;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", {31'b0, bus.busy}, 32'd0);
        repeat (2 * N) @(negedge clk);
        check("flush_start_result", bus.result, 32'hFFFF_FFFE);

        // Back-to-back: second launch in the done cycle of the first
        issue(3'b000, 32'd6, 32'd7, 32'd42, 1'b1, "b2b_mul");
        t = 0;
        while (bus.done !== 1'b1 && t < 4 * N) begin
            @(negedge clk);
            t++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL b2b_wait: got done %b, expected 1", bus.done);
        end
        issue(3'b101, 32'd9, 32'd3, 32'd3, 1'b1, "b2b_divu");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
